// File: rtl/bit_deser.sv
// bit_deser: serial-to-parallel deserializer with frame alignment.
// Hunts the incoming bit stream for the SYNC word. Once it finds SYNC, it
// assembles WIDTH-bit words, MSB first, into a single-entry output buffer
// with a valid/ready handshake. A word that completes while the buffer is
// still full is dropped, and the sticky overflow flag records the drop.
module bit_deser #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC  = WIDTH'(8'hBC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             resync,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             locked,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] win_q, win_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] winShift;
    logic [WIDTH-1:0] asmShift;

    assign winShift = {win_q[WIDTH-2:0], bit_in};
    assign asmShift = {asm_q[WIDTH-2:0], bit_in};

    // State register: every piece of state clears as soon as reset goes low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HUNT;
            win_q   <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic. The output handshake runs independently of the
    // framing logic. A resync request overrides the bit on the same edge.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        word_d  = word_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end

        if (resync) begin
            state_d = HUNT;
            win_d   = '0;
            cnt_d   = '0;
            asm_d   = '0;
            ovf_d   = 1'b0;
        end else if (bit_valid) begin
            unique case (state_q)
                HUNT: begin
                    win_d = winShift;
                    if (winShift == SYNC) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end
                end
                LOCKED: begin
                    asm_d = asmShift;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
                        if (!valid_q || word_ready) begin
                            word_d  = asmShift;
                            valid_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign locked     = (state_q == LOCKED);
    assign overflow   = ovf_q;

endmodule
